// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Clocked arbiter that hands the single memory_unit port to one of NUM_CH
//   requesters, registers the winner's command and runs the execute/ready
//   handshake to completion. A channel can hold ch_lock to keep ownership
//   across several back-to-back accesses.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   ch_execute        per-channel request, held until that channel's ch_done
//   ch_lock           per-channel lock, only honoured for the current owner
//   ch_func           flattened, channel i at [2*i +: 2]
//   ch_address1/2     flattened, channel i at [i*ADDR_W +: ADDR_W]
//   ch_write_data     flattened, channel i at [i*DATA_W +: DATA_W]
//   mem_ready         is_ready from memory_unit
//   mem_*             registered command towards memory_unit
//   ch_done           one-cycle completion pulse to the owner
//   grant             one-hot current owner, 0 when nobody owns the port
//   busy              high whenever the FSM is outside IDLE
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | arbitrate among eligible requests while memory is ready
// ISSUE     | mem_execute high for exactly this cycle
// WAIT_BUSY | wait for memory to drop ready (accept a command)
// WAIT_DONE | wait for memory to raise ready again (command finished)
// DONE      | ch_done pulse to the owner, read data valid at memory
module mem_arbiter #(
  parameter int NUM_CH  = 5,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter bit RR_MODE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_execute,
  input  logic [NUM_CH-1:0]        ch_lock,
  input  logic [2*NUM_CH-1:0]      ch_func,
  input  logic [ADDR_W*NUM_CH-1:0] ch_address1,
  input  logic [ADDR_W*NUM_CH-1:0] ch_address2,
  input  logic [DATA_W*NUM_CH-1:0] ch_write_data,
  input  logic                     mem_ready,
  output logic                     mem_execute,
  output logic [1:0]               mem_func,
  output logic [ADDR_W-1:0]        mem_address1,
  output logic [ADDR_W-1:0]        mem_address2,
  output logic [DATA_W-1:0]        mem_write_data,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        grant,
  output logic                     busy
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] ONE = 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_last;
  logic [PTR_W-1:0]  owner;
  logic              lock_valid;
  logic              lock_hold;
  logic [NUM_CH-1:0] eligible;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  int                cand;

  logic [1:0]        func_a  [NUM_CH];
  logic [ADDR_W-1:0] addr1_a [NUM_CH];
  logic [ADDR_W-1:0] addr2_a [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign func_a[i]  = ch_func[2*i +: 2];
    assign addr1_a[i] = ch_address1[i*ADDR_W +: ADDR_W];
    assign addr2_a[i] = ch_address2[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = ch_write_data[i*DATA_W +: DATA_W];
  end

  // The retained owner only blocks others while its lock is still high, so a
  // lock dropped during IDLE reopens arbitration in that very cycle.
  assign lock_hold = lock_valid && ch_lock[owner];

  always_comb begin
    eligible = ch_execute;
    if (lock_hold) eligible = ch_execute & (ONE << owner);
  end

  // Round-robin search starts just after the last winner; fixed priority
  // starts at channel 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = RR_MODE ? (int'(rr_last) + 1 + k) % NUM_CH : k;
      if (!win_found && eligible[PTR_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_last        <= PTR_W'(NUM_CH - 1);
      owner          <= '0;
      lock_valid     <= 1'b0;
      mem_execute    <= 1'b0;
      mem_func       <= '0;
      mem_address1   <= '0;
      mem_address2   <= '0;
      mem_write_data <= '0;
      ch_done        <= '0;
      grant          <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_ready && win_found) begin
            owner          <= win_idx;
            rr_last        <= win_idx;
            grant          <= ONE << win_idx;
            mem_func       <= func_a[win_idx];
            mem_address1   <= addr1_a[win_idx];
            mem_address2   <= addr2_a[win_idx];
            mem_write_data <= wdata_a[win_idx];
            mem_execute    <= 1'b1;
            busy           <= 1'b1;
            state          <= ISSUE;
          end else if (!lock_hold) begin
            lock_valid <= 1'b0;
            grant      <= '0;
          end
        end
        ISSUE: begin
          mem_execute <= 1'b0;
          state       <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!mem_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (mem_ready) begin
            ch_done <= grant;
            state   <= DONE;
          end
        end
        DONE: begin
          ch_done    <= '0;
          busy       <= 1'b0;
          lock_valid <= ch_lock[owner];
          if (!ch_lock[owner]) grant <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int N  = 5;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    ch_execute = '0;
  logic [N-1:0]    ch_lock = '0;
  logic [2*N-1:0]  ch_func = '0;
  logic [AW*N-1:0] ch_address1 = '0;
  logic [AW*N-1:0] ch_address2 = '0;
  logic [DW*N-1:0] ch_write_data = '0;

  logic          r_exec, p_exec, r_busy, p_busy;
  logic [1:0]    r_func, p_func;
  logic [AW-1:0] r_a1, r_a2, p_a1, p_a2;
  logic [DW-1:0] r_wd, p_wd;
  logic [N-1:0]  r_done, p_done, r_grant, p_grant;

  // memory model per DUT: index 0 = round-robin instance, 1 = priority
  logic [1:0] mem_ready_v;
  int         mcnt [2];
  int         busy_len = 1;

  mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .ch_execute(ch_execute), .ch_lock(ch_lock),
    .ch_func(ch_func), .ch_address1(ch_address1), .ch_address2(ch_address2),
    .ch_write_data(ch_write_data), .mem_ready(mem_ready_v[0]),
    .mem_execute(r_exec), .mem_func(r_func), .mem_address1(r_a1),
    .mem_address2(r_a2), .mem_write_data(r_wd), .ch_done(r_done),
    .grant(r_grant), .busy(r_busy));

  mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b0)) dut_pr (
    .clk(clk), .rst(rst), .ch_execute(ch_execute), .ch_lock(ch_lock),
    .ch_func(ch_func), .ch_address1(ch_address1), .ch_address2(ch_address2),
    .ch_write_data(ch_write_data), .mem_ready(mem_ready_v[1]),
    .mem_execute(p_exec), .mem_func(p_func), .mem_address1(p_a1),
    .mem_address2(p_a2), .mem_write_data(p_wd), .ch_done(p_done),
    .grant(p_grant), .busy(p_busy));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready_v <= 2'b11;
      mcnt[0] <= 0;
      mcnt[1] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((i == 0) ? r_exec : p_exec) begin
          mem_ready_v[i] <= 1'b0;
          mcnt[i] <= busy_len - 1;
        end else if (!mem_ready_v[i]) begin
          if (mcnt[i] == 0) mem_ready_v[i] <= 1'b1;
          else mcnt[i] <= mcnt[i] - 1;
        end
      end
    end
  end

  logic         cur_rr = 1'b1;
  logic         s_exec, s_busy;
  logic [N-1:0] s_done, s_grant;
  assign s_exec  = cur_rr ? r_exec  : p_exec;
  assign s_busy  = cur_rr ? r_busy  : p_busy;
  assign s_done  = cur_rr ? r_done  : p_done;
  assign s_grant = cur_rr ? r_grant : p_grant;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input string name, input bit want_done);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = want_done ? (s_done != '0) : s_exec;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: event not seen within 100 cycles, required within bound", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ch_execute = '0; ch_lock = '0; ch_func = '0;
    ch_address1 = '0; ch_address2 = '0; ch_write_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] exec0;
    bit           rr;
    int           n;
    logic [23:0]  seq;     // expected winner of transaction k at [4*k +: 4]
    int           chg_at;  // after this transaction's done, requests become exec1
    logic [N-1:0] exec1;
    int           blen;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [3:0]   ei;
    logic [N-1:0] eoh;
    logic [33:0]  cap;
    int           execs, dones;
    bit           in_txn;

    vecs[0] = '{5'b10011, 1'b1, 6, 24'h410410, -1, 5'b00000, 1};
    vecs[1] = '{5'b01010, 1'b0, 4, 24'h003111,  2, 5'b01000, 1};
    vecs[2] = '{5'b11111, 1'b1, 6, 24'h043210, -1, 5'b00000, 2};
    vecs[3] = '{5'b11111, 1'b0, 3, 24'h000000, -1, 5'b00000, 3};
    vecs[4] = '{5'b10100, 1'b1, 4, 24'h004242, -1, 5'b00000, 1};
    vecs[5] = '{5'b10000, 1'b1, 2, 24'h000044, -1, 5'b00000, 2};

    // single request on channel 2, exact cycle timing
    cur_rr = 1'b1; busy_len = 1;
    do_reset();
    chk("reset exec", r_exec, 0);
    chk("reset grant", r_grant, 0);
    chk("reset busy", r_busy, 0);
    chk("reset done", r_done, 0);
    chk("reset mem regs", {r_func, r_a1, r_a2, r_wd}, 0);
    ch_func[4 +: 2] = 2'd1;
    ch_address1[2*AW +: AW] = 8'h10;
    ch_address2[2*AW +: AW] = 8'h22;
    ch_write_data[2*DW +: DW] = 16'hABCD;
    ch_execute[2] = 1'b1;
    @(negedge clk);
    chk("A exec", r_exec, 1);
    chk("A cmd", {r_func, r_a1, r_a2, r_wd}, {2'd1, 8'h10, 8'h22, 16'hABCD});
    chk("A grant", r_grant, 5'b00100);
    chk("A busy", r_busy, 1);
    @(negedge clk);
    chk("A exec one cycle", r_exec, 0);
    @(negedge clk);
    chk("A no early done", r_done, 0);
    @(negedge clk);
    chk("A done", r_done, 5'b00100);
    ch_execute[2] = 1'b0;
    @(negedge clk);
    chk("A done pulse", r_done, 0);
    chk("A grant cleared", r_grant, 0);
    chk("A busy cleared", r_busy, 0);
    repeat (2) @(negedge clk);
    chk("A no reissue", r_exec, 0);

    // contention vectors
    for (int v = 0; v < 6; v++) begin
      cur_rr = vecs[v].rr;
      busy_len = vecs[v].blen;
      do_reset();
      ch_execute = vecs[v].exec0;
      for (int k = 0; k < vecs[v].n; k++) begin
        ei = vecs[v].seq[4*k +: 4];
        eoh = 5'b00001 << ei;
        wait_for($sformatf("v%0d issue %0d", v, k), 1'b0);
        chk($sformatf("v%0d grant %0d", v, k), s_grant, eoh);
        wait_for($sformatf("v%0d wait done %0d", v, k), 1'b1);
        chk($sformatf("v%0d done %0d", v, k), s_done, eoh);
        if (k == vecs[v].chg_at) ch_execute = vecs[v].exec1;
      end
      ch_execute = '0;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d idle busy", v), s_busy, 0);
    end

    // lock held by ch 3 over three transactions while ch 0 waits
    cur_rr = 1'b1; busy_len = 2;
    do_reset();
    ch_lock[3] = 1'b1;
    ch_execute[3] = 1'b1;
    wait_for("B issue 0", 1'b0);
    chk("B grant 0", r_grant, 5'b01000);
    ch_execute[0] = 1'b1;
    wait_for("B done 0", 1'b1);
    for (int k = 1; k < 3; k++) begin
      wait_for($sformatf("B issue %0d", k), 1'b0);
      chk($sformatf("B grant %0d", k), r_grant, 5'b01000);
      if (k == 2) begin
        ch_lock[3] = 1'b0;
        ch_execute[3] = 1'b0;
      end
      wait_for($sformatf("B done %0d", k), 1'b1);
      chk($sformatf("B done %0d", k), r_done, 5'b01000);
    end
    @(negedge clk);
    chk("B idle gap", r_exec, 0);
    @(negedge clk);
    chk("B ch0 exec", r_exec, 1);
    chk("B ch0 grant", r_grant, 5'b00001);
    wait_for("B ch0 done", 1'b1);
    ch_execute[0] = 1'b0;

    // lock released during IDLE opens arbitration on the next edge
    do_reset();
    ch_lock[3] = 1'b1;
    ch_execute[3] = 1'b1;
    wait_for("B2 issue", 1'b0);
    ch_execute[0] = 1'b1;
    wait_for("B2 done", 1'b1);
    ch_execute[3] = 1'b0;
    repeat (3) @(negedge clk);
    chk("B2 held idle exec", r_exec, 0);
    chk("B2 grant retained", r_grant, 5'b01000);
    chk("B2 idle busy", r_busy, 0);
    ch_lock[3] = 1'b0;
    @(negedge clk);
    chk("B2 release exec", r_exec, 1);
    chk("B2 release grant", r_grant, 5'b00001);
    wait_for("B2 ch0 done", 1'b1);
    ch_execute[0] = 1'b0;

    // asynchronous reset in WAIT_DONE and in ISSUE
    busy_len = 7;
    do_reset();
    ch_execute[1] = 1'b1;
    wait_for("C issue", 1'b0);
    chk("C grant", r_grant, 5'b00010);
    repeat (3) @(negedge clk);
    chk("C busy before reset", r_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("C exec in reset", r_exec, 0);
    chk("C grant in reset", r_grant, 0);
    chk("C busy in reset", r_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    ch_execute = 5'b00111;
    wait_for("C2 issue", 1'b0);
    chk("C2 grant", r_grant, 5'b00001);
    #2 rst = 1'b1;
    #1;
    chk("C2 exec drops", r_exec, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_for("C3 issue", 1'b0);
    chk("C3 grant", r_grant, 5'b00001);

    // 7-cycle busy memory, ch 4 inputs scrambled every cycle
    cur_rr = 1'b1; busy_len = 7;
    do_reset();
    ch_func[8 +: 2] = 2'd2;
    ch_address1[4*AW +: AW] = 8'h5A;
    ch_address2[4*AW +: AW] = 8'hC3;
    ch_write_data[4*DW +: DW] = 16'h1234;
    ch_execute[4] = 1'b1;
    execs = 0; dones = 0; in_txn = 1'b0; cap = '0;
    for (int c = 0; c < 300 && dones < 3; c++) begin
      @(negedge clk);
      if (r_exec) begin
        execs++;
        in_txn = 1'b1;
        cap = {r_func, r_a1, r_a2, r_wd};
        chk("D latch", cap, {ch_func[8 +: 2], ch_address1[4*AW +: AW],
                             ch_address2[4*AW +: AW], ch_write_data[4*DW +: DW]});
      end else if (in_txn) begin
        chk("D hold", {r_func, r_a1, r_a2, r_wd}, cap);
      end
      if (r_done != '0) begin
        dones++;
        chk("D done", r_done, 5'b10000);
        in_txn = 1'b0;
        if (dones == 3) ch_execute[4] = 1'b0;
      end
      ch_func[8 +: 2] = 2'($urandom);
      ch_address1[4*AW +: AW] = AW'($urandom);
      ch_address2[4*AW +: AW] = AW'($urandom);
      ch_write_data[4*DW +: DW] = DW'($urandom);
    end
    chk("D exec count", execs, 3);
    chk("D done count", dones, 3);
    repeat (3) @(negedge clk);
    chk("D final exec", r_exec, 0);
    chk("D final busy", r_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
